// File: rtl/pll_seq_pkg.sv
// Shared types for the PLL reset/lock sequencer: FSM state encoding and
// small elaboration-time helpers.
package pll_seq_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_RST_HOLD  = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_STABLE    = 3'd2,
      ST_RELEASE   = 3'd3,
      ST_RUN       = 3'd4,
      ST_FAILED    = 3'd5
   } pll_state_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// Generic two-flop synchroniser for bringing asynchronous flags into the
// clk domain; output lags the input by two clk cycles.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             srst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_reg;
   logic [WIDTH-1:0] sync_reg;

   always_ff @(posedge clk) begin
      if (srst) begin
         meta_reg <= '0;
         sync_reg <= '0;
      end else begin
         meta_reg <= d;
         sync_reg <= meta_reg;
      end
   end

   assign q = sync_reg;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock sequencer: holds the PLL in reset, qualifies lock, then
// releases domain resets in a staggered order. Optional PLL_LOCK_LOSS_CNT_EN adds lock_loss_count.
module pll_reset_sequencer
   import pll_seq_pkg::*;
#(
   parameter int NUM_DOMAINS         = 5,
   parameter int RST_HOLD_CYCLES     = 8,
   parameter int LOCK_STABLE_CYCLES  = 64,
   parameter int LOCK_TIMEOUT_CYCLES = 4096,
   parameter int RELEASE_GAP_CYCLES  = 4,
   parameter int MAX_RETRIES         = 3,
   localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   locked,
   input  logic                   relock_req,
   output logic                   pll_reset,
   output logic [NUM_DOMAINS-1:0] domain_reset,
   output logic                   all_ready,
   output logic                   failed,
   output logic [STATE_W-1:0]     state,
   output logic [RW-1:0]          retry_count
`ifdef PLL_LOCK_LOSS_CNT_EN
   ,
   output logic [7:0]             lock_loss_count
`endif
);

   // The shared counter only ever needs to reach the longest per-state terminal value.
   localparam int CNT_MAX = max_int(max_int(RST_HOLD_CYCLES - 1, LOCK_TIMEOUT_CYCLES - 1),
                                    max_int(LOCK_STABLE_CYCLES - 1,
                                            RELEASE_GAP_CYCLES * (NUM_DOMAINS - 1)));
   localparam int CW = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] HOLD_LAST    = CW'(RST_HOLD_CYCLES - 1);
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CW-1:0] REL_LAST     = CW'(RELEASE_GAP_CYCLES * (NUM_DOMAINS - 1));
   localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRIES);

   logic                   locked_s;
   pll_state_e             state_reg, state_next;
   logic [CW-1:0]          cnt_reg, cnt_next;
   logic [CW:0]            cnt_inc;
   logic [RW-1:0]          retry_reg, retry_next;
   logic                   pll_reset_reg, pll_reset_next;
   logic [NUM_DOMAINS-1:0] domain_reset_reg, domain_reset_next;
   logic                   all_ready_reg, all_ready_next;
   logic                   failed_reg, failed_next;
   logic [NUM_DOMAINS-1:0] rel_open;

   sync_2ff #(.WIDTH(1)) u_lock_sync (
      .clk  (clk),
      .srst (reset),
      .d    (locked),
      .q    (locked_s)
   );

   assign cnt_inc = {1'b0, cnt_reg} + {{CW{1'b0}}, 1'b1};

   // Bit i opens once the RELEASE count about to be loaded reaches its stagger slot.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_DOMAINS; gi++) begin : g_rel
         if (gi == 0) begin : g_first
            assign rel_open[gi] = 1'b1;
         end else begin : g_later
            localparam logic [CW:0] OPEN_AT = (CW+1)'(RELEASE_GAP_CYCLES * gi);
            assign rel_open[gi] = (state_reg == ST_RELEASE) && (cnt_inc >= OPEN_AT);
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg        <= ST_RST_HOLD;
         cnt_reg          <= '0;
         retry_reg        <= '0;
         pll_reset_reg    <= 1'b1;
         domain_reset_reg <= '1;
         all_ready_reg    <= 1'b0;
         failed_reg       <= 1'b0;
      end else begin
         state_reg        <= state_next;
         cnt_reg          <= cnt_next;
         retry_reg        <= retry_next;
         pll_reset_reg    <= pll_reset_next;
         domain_reset_reg <= domain_reset_next;
         all_ready_reg    <= all_ready_next;
         failed_reg       <= failed_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      retry_next = retry_reg;
      if (relock_req) begin
         state_next = ST_RST_HOLD;
         retry_next = '0;
      end else begin
         case (state_reg)
            ST_RST_HOLD:
               if (cnt_reg == HOLD_LAST) state_next = ST_WAIT_LOCK;
            ST_WAIT_LOCK:
               if (locked_s) begin
                  state_next = ST_STABLE;
               end else if (cnt_reg == TIMEOUT_LAST) begin
                  if (retry_reg == RETRY_MAX) begin
                     state_next = ST_FAILED;
                  end else begin
                     state_next = ST_RST_HOLD;
                     retry_next = retry_reg + 1'b1;
                  end
               end
            ST_STABLE:
               if (!locked_s) state_next = ST_WAIT_LOCK;
               else if (cnt_reg == STABLE_LAST) state_next = ST_RELEASE;
            ST_RELEASE:
               if (!locked_s) state_next = ST_RST_HOLD;
               else if (cnt_reg == REL_LAST) state_next = ST_RUN;
            ST_RUN:
               if (!locked_s) state_next = ST_RST_HOLD;
            ST_FAILED:
               state_next = ST_FAILED;
            default:
               state_next = ST_RST_HOLD;
         endcase
      end

      if (state_next == ST_RUN) retry_next = '0;

      // A relock from RST_HOLD is still a fresh entry and must restart the hold time.
      if (relock_req || (state_next != state_reg)) cnt_next = '0;
      else if ((state_reg == ST_RUN) || (state_reg == ST_FAILED)) cnt_next = cnt_reg;
      else cnt_next = cnt_inc[CW-1:0];

      pll_reset_next    = (state_next == ST_RST_HOLD) || (state_next == ST_FAILED);
      domain_reset_next = '1;
      if (state_next == ST_RELEASE) domain_reset_next = ~rel_open;
      else if (state_next == ST_RUN) domain_reset_next = '0;
      all_ready_next = (state_next == ST_RUN);
      failed_next    = (state_next == ST_FAILED);
   end

`ifdef PLL_LOCK_LOSS_CNT_EN
   logic       lock_lost;
   logic [7:0] loss_cnt_reg;

   assign lock_lost = !relock_req && !locked_s &&
                      ((state_reg == ST_RELEASE) || (state_reg == ST_RUN));

   always_ff @(posedge clk) begin
      if (reset || relock_req) loss_cnt_reg <= '0;
      else if (lock_lost && (loss_cnt_reg != 8'hFF)) loss_cnt_reg <= loss_cnt_reg + 8'd1;
   end

   assign lock_loss_count = loss_cnt_reg;
`endif

   assign pll_reset    = pll_reset_reg;
   assign domain_reset = domain_reset_reg;
   assign all_ready    = all_ready_reg;
   assign failed       = failed_reg;
   assign state        = state_reg;
   assign retry_count  = retry_reg;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer: stimulus queues expected output
// changes with their spacing in cycles; a monitor checks every output change.
module tb_pll_reset_sequencer;

   localparam int ND = 5;

   logic          clk = 1'b0;
   logic          reset;
   logic          locked;
   logic          relock_req;
   logic          pll_reset;
   logic [ND-1:0] domain_reset;
   logic          all_ready;
   logic          failed;
   logic [2:0]    state;
   logic [1:0]    retry_count;
`ifdef PLL_LOCK_LOSS_CNT_EN
   logic [7:0]    lock_loss_count;
`endif

   typedef struct {
      logic [12:0] v;
      int          dt;
   } exp_t;

   exp_t        exp_q[$];
   int          checks   = 0;
   int          errors   = 0;
   int          cyc      = 0;
   int          last_cyc = 0;
   int          ev_idx   = 0;
   logic [12:0] last_snap = 13'bx;

   pll_reset_sequencer #(
      .NUM_DOMAINS         (ND),
      .RST_HOLD_CYCLES     (8),
      .LOCK_STABLE_CYCLES  (64),
      .LOCK_TIMEOUT_CYCLES (32),
      .RELEASE_GAP_CYCLES  (4),
      .MAX_RETRIES         (3)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .locked       (locked),
      .relock_req   (relock_req),
      .pll_reset    (pll_reset),
      .domain_reset (domain_reset),
      .all_ready    (all_ready),
      .failed       (failed),
      .state        (state),
      .retry_count  (retry_count)
`ifdef PLL_LOCK_LOSS_CNT_EN
      ,
      .lock_loss_count (lock_loss_count)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every change of the output bundle is one transaction.
   always @(negedge clk) begin
      logic [12:0] snap;
      exp_t        e;
      int          dt;
      snap = {state, pll_reset, domain_reset, all_ready, failed, retry_count};
      if (snap !== last_snap) begin
         dt = cyc - last_cyc;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_change cyc=%0d: got %h, no change was expected", cyc, snap);
         end else begin
            e = exp_q.pop_front();
            if ((snap !== e.v) || ((e.dt != 0) && (dt != e.dt))) begin
               errors++;
               $display("FAIL ev%0d cyc=%0d: got %h after %0d cycles, required %h after %0d cycles",
                        ev_idx, cyc, snap, dt, e.v, e.dt);
            end else begin
               $display("ok   ev%0d cyc=%0d: state=%0d pll_reset=%b domain_reset=%b all_ready=%b failed=%b retry=%0d dt=%0d",
                        ev_idx, cyc, state, pll_reset, domain_reset, all_ready, failed, retry_count, dt);
            end
            ev_idx++;
         end
         last_snap = snap;
         last_cyc  = cyc;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_ev(input logic [2:0] st, input logic pr, input logic [4:0] dr,
                          input logic ar, input logic fl, input logic [1:0] rc, input int dt);
      exp_t e;
      e.v  = {st, pr, dr, ar, fl, rc};
      e.dt = dt;
      exp_q.push_back(e);
   endtask

   // RELEASE stagger: bit0 falls on entry after 64 qualified cycles, then every 4 cycles.
   task automatic push_rel_tail();
      push_ev(3'd3, 1'b0, 5'b11110, 1'b0, 1'b0, 2'd0, 64);
      push_ev(3'd3, 1'b0, 5'b11100, 1'b0, 1'b0, 2'd0, 4);
      push_ev(3'd3, 1'b0, 5'b11000, 1'b0, 1'b0, 2'd0, 4);
      push_ev(3'd3, 1'b0, 5'b10000, 1'b0, 1'b0, 2'd0, 4);
      push_ev(3'd3, 1'b0, 5'b00000, 1'b0, 1'b0, 2'd0, 4);
      push_ev(3'd4, 1'b0, 5'b00000, 1'b1, 1'b0, 2'd0, 1);
   endtask

   // Lock driven 12 cycles after pll_reset falls; 3 cycles through synchroniser + FSM.
   task automatic push_nominal(input int first_dt);
      push_ev(3'd1, 1'b0, 5'b11111, 1'b0, 1'b0, 2'd0, first_dt);
      push_ev(3'd2, 1'b0, 5'b11111, 1'b0, 1'b0, 2'd0, 15);
      push_rel_tail();
   endtask

`ifdef PLL_LOCK_LOSS_CNT_EN
   task automatic check_loss(input string name, input logic [7:0] want);
      checks++;
      if (lock_loss_count !== want) begin
         errors++;
         $display("FAIL %s: lock_loss_count got %0d, required %0d", name, lock_loss_count, want);
      end else begin
         $display("ok   %s: lock_loss_count=%0d", name, lock_loss_count);
      end
   endtask
`endif

   initial begin
      reset      = 1'b1;
      locked     = 1'b0;
      relock_req = 1'b0;

      // Nominal bring-up, then lock loss in RUN and a second bring-up.
      push_ev(3'd0, 1'b1, 5'b11111, 1'b0, 1'b0, 2'd0, 0);
      tick(3);
      reset = 1'b0;
      push_nominal(0);
      tick(20);
      locked = 1'b1;
      tick(94);
      locked = 1'b0;
      push_ev(3'd0, 1'b1, 5'b11111, 1'b0, 1'b0, 2'd0, 13);
      push_nominal(8);
      tick(23);
      locked = 1'b1;
      tick(90);
`ifdef PLL_LOCK_LOSS_CNT_EN
      check_loss("loss_after_run_drop", 8'd1);
`endif

      // Reset coincident with relock_req while in RUN.
      reset      = 1'b1;
      relock_req = 1'b1;
      locked     = 1'b0;
      push_ev(3'd0, 1'b1, 5'b11111, 1'b0, 1'b0, 2'd0, 0);
      tick(1);
      relock_req = 1'b0;
      tick(3);
      reset = 1'b0;
`ifdef PLL_LOCK_LOSS_CNT_EN
      check_loss("loss_after_reset", 8'd0);
`endif

      // relock_req once domain_reset[1] has fallen.
      push_ev(3'd1, 1'b0, 5'b11111, 1'b0, 1'b0, 2'd0, 0);
      push_ev(3'd2, 1'b0, 5'b11111, 1'b0, 1'b0, 2'd0, 15);
      push_ev(3'd3, 1'b0, 5'b11110, 1'b0, 1'b0, 2'd0, 64);
      push_ev(3'd3, 1'b0, 5'b11100, 1'b0, 1'b0, 2'd0, 4);
      push_ev(3'd0, 1'b1, 5'b11111, 1'b0, 1'b0, 2'd0, 2);
      tick(20);
      locked = 1'b1;
      tick(72);
      relock_req = 1'b1;
      tick(1);
      relock_req = 1'b0;

      // Lock still present: immediate STABLE, then a 3-cycle glitch at STABLE cycle 40.
      push_ev(3'd1, 1'b0, 5'b11111, 1'b0, 1'b0, 2'd0, 8);
      push_ev(3'd2, 1'b0, 5'b11111, 1'b0, 1'b0, 2'd0, 1);
      push_ev(3'd1, 1'b0, 5'b11111, 1'b0, 1'b0, 2'd0, 40);
      push_ev(3'd2, 1'b0, 5'b11111, 1'b0, 1'b0, 2'd0, 3);
      push_rel_tail();
      tick(46);
      locked = 1'b0;
      tick(3);
      locked = 1'b1;
      tick(90);

      // Timeout/retry to FAILED with no lock, then relock_req recovery.
      reset  = 1'b1;
      locked = 1'b0;
      push_ev(3'd0, 1'b1, 5'b11111, 1'b0, 1'b0, 2'd0, 0);
      tick(4);
      reset = 1'b0;
      push_ev(3'd1, 1'b0, 5'b11111, 1'b0, 1'b0, 2'd0, 0);
      push_ev(3'd0, 1'b1, 5'b11111, 1'b0, 1'b0, 2'd1, 32);
      push_ev(3'd1, 1'b0, 5'b11111, 1'b0, 1'b0, 2'd1, 8);
      push_ev(3'd0, 1'b1, 5'b11111, 1'b0, 1'b0, 2'd2, 32);
      push_ev(3'd1, 1'b0, 5'b11111, 1'b0, 1'b0, 2'd2, 8);
      push_ev(3'd0, 1'b1, 5'b11111, 1'b0, 1'b0, 2'd3, 32);
      push_ev(3'd1, 1'b0, 5'b11111, 1'b0, 1'b0, 2'd3, 8);
      push_ev(3'd5, 1'b1, 5'b11111, 1'b0, 1'b1, 2'd3, 32);
      push_ev(3'd0, 1'b1, 5'b11111, 1'b0, 1'b0, 2'd0, 11);
      push_ev(3'd1, 1'b0, 5'b11111, 1'b0, 1'b0, 2'd0, 8);
      tick(170);
      relock_req = 1'b1;
      tick(1);
      relock_req = 1'b0;
      tick(15);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL pending_events: %0d expected changes never seen, required 0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
